// File: rtl/spi_instr_deserializer.sv
// SPI instruction deserializer: frames opcode/key/text off a
// synchronized SPI link and queues them in a small FIFO.
module spi_instr_deserializer #(
    parameter int ADDRW = 8,
    parameter int OPW   = 2,
    parameter int DEPTH = 2,
    parameter int CPOL  = 0,
    parameter int CPHA  = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             spi_clk,
    input  logic             mosi,
    input  logic             cs_n,
    input  logic             ready_in,
    output logic [OPW-1:0]   opcode,
    output logic [ADDRW-1:0] key_addr,
    output logic [ADDRW-1:0] text_addr,
    output logic             valid_out,
    output logic             frame_err,
    output logic             overflow
);

    localparam int   FW       = OPW + 2 * ADDRW;
    localparam int   CW       = $clog2(FW + 1);
    localparam int   AW       = $clog2(DEPTH);
    localparam logic SCK_IDLE = (CPOL != 0) ? 1'b1 : 1'b0;
    localparam bit   RISE     = (CPOL == CPHA);

    logic [1:0]    sck_q;
    logic [1:0]    cs_q;
    logic [1:0]    mosi_q;
    logic          sck_d;
    logic          cs_d;
    logic          sck_s;
    logic          cs_s;
    logic          mosi_s;
    logic          sck_edge;
    logic          sample;
    logic          cs_rise;
    logic          cs_fall;
    logic          last;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic          push_ok;
    logic [CW-1:0] cnt;
    logic [FW-1:0] sreg;
    logic [FW-1:0] frame;
    logic [FW-1:0] head;
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;
    logic [FW-1:0] mem [DEPTH];

    assign sck_s  = sck_q[1];
    assign cs_s   = cs_q[1];
    assign mosi_s = mosi_q[1];

    // Two-flop synchronizers plus one history flop for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_q  <= {2{SCK_IDLE}};
            cs_q   <= 2'b11;
            mosi_q <= 2'b00;
            sck_d  <= SCK_IDLE;
            cs_d   <= 1'b1;
        end else begin
            sck_q  <= {sck_q[0], spi_clk};
            cs_q   <= {cs_q[0], cs_n};
            mosi_q <= {mosi_q[0], mosi};
            sck_d  <= sck_s;
            cs_d   <= cs_s;
        end
    end

    assign sck_edge = RISE ? (!sck_d && sck_s) : (sck_d && !sck_s);
    assign cs_rise  = !cs_d && cs_s;
    assign cs_fall  = cs_d && !cs_s;
    assign sample   = sck_edge && !cs_s && !cs_fall;
    assign last     = (cnt == CW'(FW - 1));
    assign frame    = (sreg << 1) | FW'(mosi_s);
    assign push     = sample && last;

    // Bit counter, shift register and abort detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            sreg      <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (cs_rise) begin
                cnt       <= '0;
                frame_err <= (cnt != '0);
            end else if (cs_fall) begin
                cnt <= '0;
            end else if (sample) begin
                sreg <= frame;
                cnt  <= last ? '0 : cnt + 1'b1;
            end
        end
    end

    assign empty     = (wptr == rptr);
    assign full      = (wptr[AW] != rptr[AW]) &&
                       (wptr[AW-1:0] == rptr[AW-1:0]);
    assign valid_out = !empty;
    assign pop       = valid_out && ready_in;
    assign push_ok   = push && (!full || pop);

    // FIFO pointers and overflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr     <= '0;
            rptr     <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= push && full && !pop;
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop)     rptr <= rptr + 1'b1;
        end
    end

    // FIFO storage; contents are masked while empty so no reset needed
    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr[AW-1:0]] <= frame;
    end

    assign head      = mem[rptr[AW-1:0]];
    assign opcode    = valid_out ? head[FW-1 -: OPW] : '0;
    assign key_addr  = valid_out ? head[2*ADDRW-1 -: ADDRW] : '0;
    assign text_addr = valid_out ? head[ADDRW-1:0] : '0;

endmodule

// File: tb/tb_spi_instr_deserializer.sv
// Directed bench for spi_instr_deserializer: a mode-0 instance and
// a mode-3 instance sharing mosi, cs_n and reset.
module tb_spi_instr_deserializer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sck0;
    logic       sck3;
    logic       mosi;
    logic       cs_n;
    logic       ready0;
    logic       ready3;
    logic [1:0] op0, op3;
    logic [7:0] key0, key3, text0, text3;
    logic       valid0, valid3, ferr0, ferr3, ovf0, ovf3;

    int n_vec  = 0;
    int n_fail = 0;
    int n_vhi  = 0;
    int n_ferr = 0;
    int n_ovf  = 0;
    logic [17:0] cap[$];
    logic [17:0] cap3[$];

    typedef struct {
        logic [17:0] frame;
        logic [1:0]  op;
        logic [7:0]  key;
        logic [7:0]  text;
    } vec_t;

    vec_t tbl[6];

    spi_instr_deserializer dut0 (
        .clk(clk), .rst_n(rst_n), .spi_clk(sck0), .mosi(mosi),
        .cs_n(cs_n), .ready_in(ready0), .opcode(op0),
        .key_addr(key0), .text_addr(text0), .valid_out(valid0),
        .frame_err(ferr0), .overflow(ovf0)
    );

    spi_instr_deserializer #(.CPOL(1), .CPHA(1)) dut3 (
        .clk(clk), .rst_n(rst_n), .spi_clk(sck3), .mosi(mosi),
        .cs_n(cs_n), .ready_in(ready3), .opcode(op3),
        .key_addr(key3), .text_addr(text3), .valid_out(valid3),
        .frame_err(ferr3), .overflow(ovf3)
    );

    always #5 clk = ~clk;

    // Observe outputs on the falling edge, away from state updates
    always @(negedge clk) begin
        if (valid0) n_vhi++;
        if (ferr0 || ferr3) n_ferr++;
        if (ovf0 || ovf3) n_ovf++;
        if (valid0 && ready0) cap.push_back({op0, key0, text0});
        if (valid3 && ready3) cap3.push_back({op3, key3, text3});
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_cap(input string name, input logic [17:0] exp);
        logic [17:0] got;
        got = 'x;
        if (cap.size() != 0) got = cap.pop_front();
        chk(name, 32'(got), 32'(exp));
    endtask

    task automatic clr();
        @(posedge clk);
        n_vhi  = 0;
        n_ferr = 0;
        n_ovf  = 0;
        cap.delete();
        cap3.delete();
    endtask

    task automatic send_bit(input logic b, input bit m3);
        mosi = b;
        if (m3) begin
            sck3 = 1'b0;
            #40;
            sck3 = 1'b1;
            #40;
        end else begin
            #40;
            sck0 = 1'b1;
            #40;
            sck0 = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [17:0] f, input bit m3);
        for (int i = 17; i >= 0; i--) send_bit(f[i], m3);
    endtask

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
    endtask

    initial begin
        tbl[0] = '{18'h23CA5, 2'b10, 8'h3C, 8'hA5};
        tbl[1] = '{18'h101FE, 2'b01, 8'h01, 8'hFE};
        tbl[2] = '{18'h3AA55, 2'b11, 8'hAA, 8'h55};
        tbl[3] = '{18'h00000, 2'b00, 8'h00, 8'h00};
        tbl[4] = '{18'h3FFFF, 2'b11, 8'hFF, 8'hFF};
        tbl[5] = '{18'h18001, 2'b01, 8'h80, 8'h01};

        rst_n  = 1'b0;
        sck0   = 1'b0;
        sck3   = 1'b1;
        mosi   = 1'b0;
        cs_n   = 1'b1;
        ready0 = 1'b1;
        ready3 = 1'b1;
        #23;
        chk("reset_out0", {valid0, op0, key0, text0, ferr0, ovf0}, 0);
        chk("reset_out3", {valid3, op3, key3, text3, ferr3, ovf3}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wclk(4);

        // Single frames, one per cs_n window, drained immediately
        for (int v = 0; v < 6; v++) begin
            clr();
            cs_n = 1'b0;
            wclk(4);
            send_frame(tbl[v].frame, 1'b0);
            cs_n = 1'b1;
            wclk(20);
            chk($sformatf("v%0d_count", v), cap.size(), 1);
            chk_cap($sformatf("v%0d_data", v),
                    {tbl[v].op, tbl[v].key, tbl[v].text});
            chk($sformatf("v%0d_vhi", v), n_vhi, 1);
            chk($sformatf("v%0d_ferr", v), n_ferr, 0);
            @(negedge clk);
            chk($sformatf("v%0d_idle", v),
                {valid0, op0, key0, text0}, 0);
        end

        // Overflow: three frames with downstream stalled
        ready0 = 1'b0;
        clr();
        cs_n = 1'b0;
        wclk(4);
        send_frame(18'h11100, 1'b0);
        send_frame(18'h22200, 1'b0);
        wclk(10);
        chk("ovf_none_yet", n_ovf, 0);
        send_frame(18'h33300, 1'b0);
        cs_n = 1'b1;
        wclk(20);
        chk("ovf_pulse", n_ovf, 1);
        chk("ovf_full_head", {valid0, op0, key0}, {1'b1, 2'd1, 8'h11});
        @(negedge clk);
        ready0 = 1'b1;
        wclk(5);
        chk("ovf_count", cap.size(), 2);
        chk_cap("ovf_first", 18'h11100);
        chk_cap("ovf_second", 18'h22200);
        @(negedge clk);
        chk("ovf_drained", valid0, 0);

        // Abort after 9 bits, then a clean frame
        clr();
        cs_n = 1'b0;
        wclk(4);
        for (int i = 0; i < 9; i++) send_bit(i[0], 1'b0);
        cs_n = 1'b1;
        wclk(20);
        chk("abort_ferr", n_ferr, 1);
        chk("abort_novalid", n_vhi, 0);
        clr();
        cs_n = 1'b0;
        wclk(4);
        send_frame(18'h101FE, 1'b0);
        cs_n = 1'b1;
        wclk(20);
        chk_cap("abort_next", 18'h101FE);
        chk("abort_next_ferr", n_ferr, 0);

        // Back-to-back frames inside one cs_n window
        clr();
        cs_n = 1'b0;
        wclk(4);
        send_frame(18'h2C3A1, 1'b0);
        send_frame(18'h15E0F, 1'b0);
        cs_n = 1'b1;
        wclk(20);
        chk("b2b_count", cap.size(), 2);
        chk_cap("b2b_first", 18'h2C3A1);
        chk_cap("b2b_second", 18'h15E0F);
        chk("b2b_ferr", n_ferr, 0);

        // Mode 3 instance
        clr();
        cs_n = 1'b0;
        wclk(4);
        send_frame(18'h1807F, 1'b1);
        cs_n = 1'b1;
        wclk(20);
        chk("mode3_count", cap3.size(), 1);
        chk("mode3_data", (cap3.size() != 0) ? cap3[0] : 'x, 18'h1807F);
        chk("mode3_ferr", n_ferr, 0);
        chk("mode3_dut0_quiet", cap.size(), 0);

        // Reset mid-frame with a queued entry
        ready0 = 1'b0;
        clr();
        cs_n = 1'b0;
        wclk(4);
        send_frame(18'h0ABCD, 1'b0);
        for (int i = 0; i < 10; i++) send_bit(1'b1, 1'b0);
        wclk(2);
        chk("rst_pre_valid", valid0, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_out", {valid0, op0, key0, text0, ferr0, ovf0}, 0);
        wclk(3);
        @(negedge clk);
        rst_n = 1'b1;
        wclk(10);
        chk("rst_no_pulse", n_ferr + n_ovf, 0);
        cs_n = 1'b1;
        wclk(6);
        chk("rst_no_pulse2", n_ferr + n_ovf, 0);
        chk("rst_empty", valid0, 0);
        ready0 = 1'b1;
        clr();
        cs_n = 1'b0;
        wclk(4);
        send_frame(18'h3AA55, 1'b0);
        cs_n = 1'b1;
        wclk(20);
        chk("rst_next_count", cap.size(), 1);
        chk_cap("rst_next_data", 18'h3AA55);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
